mem_port_arbiter: RTL

//   Shares one unified memory port between the IF stage (instruction fetch) and
//   the MEM stage (LW/SW) of the 5-stage MIPS pipeline. Grants one requester at a

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and the MEM stage
//   (LW/SW). The MEM stage has fixed priority over IF because it holds the older
//   instruction. Each access runs IDLE -> wait -> DONE. DONE gives a one-cycle
//   valid pulse, and the next access is arbitrated in the IDLE cycle after it.
//   A wait that lasts TIMEOUT cycles is force-completed and sets a sticky
//   bus_err. Set TIMEOUT to 0 to disable the timeout.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request, held until if_valid
//   if_rdata/if_valid/if_stall    fetch result, completion pulse, stall (comb)
//   dm_req/dm_we/dm_addr/dm_wdata data request from the MEM stage, held until dm_valid
//   dm_rdata/dm_valid/dm_stall    load result, completion pulse, stall (comb)
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack             memory response
//   bus_err                       sticky timeout flag, cleared only by rst
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  // The wait counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST_CNT = CNT_W'(TO_LAST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              bus_err_q, bus_err_d;
  logic              timeout_hit;

  // A wait state expires with no ack. An ack in the same cycle takes precedence.
  assign timeout_hit = TO_EN && (wait_cnt_q == TO_LAST_CNT) && !mem_ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state logic. The MEM stage wins when both requesters ask in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dm_req) begin
          state_d = DM_WAIT;
        end else if (if_req) begin
          state_d = IF_WAIT;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (mem_ack || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values for the registered outputs, plus the combinational stalls.
  // The valid flags default low so each stays high only for the DONE cycle.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      IDLE: begin
        if (dm_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wait_cnt_d  = '0;
        end else if (if_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          wait_cnt_d = '0;
        end
      end
      IF_WAIT: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
        end else if (timeout_hit) begin
          mem_req_d  = 1'b0;
          if_rdata_d = '0;
          if_valid_d = 1'b1;
          bus_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      DM_WAIT: begin
        // A store leaves dm_rdata alone, both on ack and on timeout.
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // The pipeline advances in this cycle, so requests are ignored.
      end
      default: begin
      end
    endcase
  end

  // Stall until the completion pulse is seen
  always_comb begin
    if_stall = if_req & ~if_valid_q;
    dm_stall = dm_req & ~dm_valid_q;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign bus_err   = bus_err_q;

endmodule
